conv_window_feeder: RTL and testbench

Raster-stream front end for the single-MAC 3x3 convolution engine. It accepts an image one pixel per handshake and keeps two line buffers plus a 3x3 window register. For each full 3x3 neighbourhood it restarts the engine, holds the window stable until the engine's done, captures the 32-bit result and delivers it on a valid/ready output stream. It is the initiator/driver side of the engine's pixel_0..8 / rst / resultado / done interface.

---
 rtl/conv_window_feeder.sv | 181 ++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
`default_nettype none
// =============================================================================
// conv_window_feeder : raster pixel stream -> 3x3 windows for a single-MAC
// conv engine; optional `define RESULT_CLAMP_EN saturates results to [0,255].
// Revision: 1.0
// =============================================================================
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  win_0,
  output logic [7:0]  win_1,
  output logic [7:0]  win_2,
  output logic [7:0]  win_3,
  output logic [7:0]  win_4,
  output logic [7:0]  win_5,
  output logic [7:0]  win_6,
  output logic [7:0]  win_7,
  output logic [7:0]  win_8,
  output logic        conv_rst,
  input  logic [31:0] conv_result,
  input  logic        conv_done,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  // Row briefly reaches IMG_H after the last pixel, until the final result drains.
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              last_q, last_d;
  logic [8:0][7:0]   win_q, win_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              pix_ready_q, pix_ready_d;
  logic              conv_rst_q, conv_rst_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        lb0_q [IMG_W];
  logic [7:0]        lb1_q [IMG_W];
  logic              accept;
  logic [31:0]       capture;

  assign accept = pix_valid & pix_ready_q;

  always_comb begin
`ifdef RESULT_CLAMP_EN
    if (conv_result[31])
      capture = 32'd0;
    else if (|conv_result[30:8])
      capture = 32'd255;
    else
      capture = {24'd0, conv_result[7:0]};
`else
    capture = conv_result;
`endif
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    last_d     = last_q;
    win_d      = win_q;
    res_data_d = res_data_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
          win_d[2] = lb1_q[col_q];
          win_d[3] = win_q[4];
          win_d[4] = win_q[5];
          win_d[5] = lb0_q[col_q];
          win_d[6] = win_q[7];
          win_d[7] = win_q[8];
          win_d[8] = pix_in;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
            state_d = START;
            last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (conv_done) begin
          res_data_d = capture;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d = FILL;
          if (last_q) begin
            col_d  = '0;
            row_d  = '0;
            last_d = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
    pix_ready_d = (state_d == FILL);
    conv_rst_d  = (state_d != WAIT);
    res_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      win_q       <= '0;
      res_data_q  <= '0;
      pix_ready_q <= 1'b0;
      conv_rst_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_q      <= last_d;
      win_q       <= win_d;
      res_data_q  <= res_data_d;
      pix_ready_q <= pix_ready_d;
      conv_rst_q  <= conv_rst_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Line buffers carry no reset; rows 0 and 1 never form a window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign conv_rst   = conv_rst_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign frame_done = res_valid_q & res_ready & last_q;
  assign win_0 = win_q[0];
  assign win_1 = win_q[1];
  assign win_2 = win_q[2];
  assign win_3 = win_q[3];
  assign win_4 = win_q[4];
  assign win_5 = win_q[5];
  assign win_6 = win_q[6];
  assign win_7 = win_q[7];
  assign win_8 = win_q[8];

endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// =============================================================================
// tb_conv_window_feeder : scoreboard bench for conv_window_feeder (4x4 image)
// with a delay-configurable engine model. Revision: 1.0
// =============================================================================
module tb_conv_window_feeder;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic        conv_rst;
  logic [31:0] conv_result;
  logic        conv_done;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pix_q[$];
  int         img [H][W];
  int         eng_delay = 3;
  bit         rr_random = 1'b0;
  bit         hold = 1'b0;
  int         fd_cnt = 0;

  conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
    .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
    .conv_rst(conv_rst), .conv_result(conv_result), .conv_done(conv_done),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: Laplacian-style response around window centre (r,c).
  function automatic logic [31:0] ref_result(input int r, input int c);
    int s;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0)) s += img[r+dr][c+dc];
    s -= 8 * img[r][c];
`ifdef RESULT_CLAMP_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`endif
    return 32'(s);
  endfunction

  task automatic issue_frame();
    exp_t e;
    for (int r = 1; r <= H-2; r++)
      for (int c = 1; c <= W-2; c++) begin
        e.data = ref_result(r, c);
        e.last = (r == H-2) && (c == W-2);
        exp_q.push_back(e);
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix_q.push_back(8'(img[r][c]));
  endtask

  task automatic fill_img(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pix_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n < 5000), 32'd1);
    repeat (5) @(negedge clk);
    check({name, "_idle_ready"}, 32'(pix_ready), 32'd1);
  endtask

  // Pixel driver: presents queue head, pops it once the handshake has happened.
  initial begin
    bit prev_v, prev_r;
    prev_v = 1'b0;
    prev_r = 1'b0;
    pix_valid = 1'b0;
    pix_in = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        pix_valid = 1'b0;
      end else begin
        if (prev_v && prev_r && pix_q.size() > 0) void'(pix_q.pop_front());
        if (pix_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          pix_valid = 1'b1;
          pix_in = pix_q[0];
        end else begin
          pix_valid = 1'b0;
        end
        prev_v = pix_valid;
        prev_r = pix_ready;
      end
    end
  end

  // Engine model: counts cycles out of reset, then raises done with its result.
  initial begin
    int cnt;
    logic [71:0] snap;
    int s;
    cnt = 0;
    snap = '0;
    conv_done = 1'b0;
    conv_result = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (conv_rst) begin
        cnt = 0;
        conv_done = 1'b0;
      end else begin
        if (cnt == 0) snap = {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
        cnt++;
        if (cnt == eng_delay) begin
          if (eng_delay > 1)
            check("win_stable_in_wait",
                  32'({win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8} == snap), 32'd1);
          s = int'(win_0) + int'(win_1) + int'(win_2) + int'(win_3) + int'(win_5)
            + int'(win_6) + int'(win_7) + int'(win_8) - 8 * int'(win_4);
          conv_result = 32'(s);
          conv_done = 1'b1;
        end
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold) res_ready = 1'b0;
      else if (rr_random) res_ready = ($urandom_range(0, 2) != 0);
      else res_ready = 1'b1;
    end
  end

  // Monitor: every result transfer is checked against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", res_data, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("frame_done_at_transfer", 32'(frame_done), 32'(e.last));
        end
      end else if (frame_done) begin
        check("frame_done_spurious", 32'(frame_done), 32'd0);
      end
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    logic [31:0] held;
    bit ok_valid, ok_data, ok_ready;
    bit prev;
    int falls, n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pix_ready", 32'(pix_ready), 32'd0);
    check("reset_conv_rst", 32'(conv_rst), 32'd1);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_data", res_data, 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_win", 32'({win_0, win_4, win_8} == 24'd0), 32'd1);
    #2 rst = 1'b0;

    // Flat image: every response is zero, one frame_done.
    fill_img(10);
    fd_cnt = 0;
    issue_frame();
    wait_drain("flat");
    check("flat_frame_done_count", 32'(fd_cnt), 32'd1);

    // Single impulse at (1,1).
    fill_img(0);
    img[1][1] = 100;
    eng_delay = 2;
    issue_frame();
    wait_drain("impulse");

    // Bright ring around a dark centre at (1,1).
    fill_img(255);
    img[1][1] = 0;
    issue_frame();
    wait_drain("ring");

    // Backpressure: first result held for 20 cycles.
    rand_img();
    hold = 1'b1;
    issue_frame();
    n = 0;
    while (!res_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_out", 32'(res_valid), 32'd1);
    held = res_data;
    ok_valid = 1'b1;
    ok_data = 1'b1;
    ok_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid) ok_valid = 1'b0;
      if (res_data !== held) ok_data = 1'b0;
      if (pix_ready) ok_ready = 1'b0;
    end
    check("stall_valid_held", 32'(ok_valid), 32'd1);
    check("stall_data_held", 32'(ok_data), 32'd1);
    check("stall_pix_ready_low", 32'(ok_ready), 32'd1);
    hold = 1'b0;
    wait_drain("stall");

    // Same random image across engine latencies, random downstream readiness.
    rand_img();
    rr_random = 1'b1;
    eng_delay = 1;
    issue_frame();
    wait_drain("delay1");
    eng_delay = 9;
    issue_frame();
    wait_drain("delay9");
    eng_delay = 30;
    issue_frame();
    wait_drain("delay30");

    // Reset while the engine works on the second window.
    rand_img();
    eng_delay = 9;
    issue_frame();
    prev = conv_rst;
    falls = 0;
    n = 0;
    while (falls < 2 && n < 2000) begin
      @(negedge clk);
      n++;
      if (prev && !conv_rst) falls++;
      prev = conv_rst;
    end
    check("abort_reach_wait2", 32'(falls), 32'd2);
    #2 rst = 1'b1;
    pix_q.delete();
    exp_q.delete();
    ok_valid = 1'b1;
    ok_data = 1'b1;
    ok_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!conv_rst) ok_data = 1'b0;
      if (res_valid) ok_valid = 1'b0;
      if (pix_ready) ok_ready = 1'b0;
    end
    check("abort_conv_rst_high", 32'(ok_data), 32'd1);
    check("abort_res_valid_low", 32'(ok_valid), 32'd1);
    check("abort_pix_ready_low", 32'(ok_ready), 32'd1);
    #2 rst = 1'b0;
    rand_img();
    fd_cnt = 0;
    issue_frame();
    wait_drain("after_abort");
    check("after_abort_frame_done_count", 32'(fd_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
